// File: rtl/matmul_ctrl.sv
// rtl/matmul_ctrl.sv - NxN signed matrix-multiply controller with serial load, sequential MAC and byte-serial readout
// Optional build macro TPU_RELU_EN: negative results read out as all-zero bytes.
module matmul_ctrl #(
   parameter int N  = 2,
   parameter int DW = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_en,
   input  logic                     load_sel_ab,
   input  logic [$clog2(N*N)-1:0]   load_index,
   input  logic [DW-1:0]            in_data,
   input  logic                     start,
   input  logic                     output_en,
   output logic [7:0]               out_data,
   output logic                     busy,
   output logic                     done
);
   localparam int AW = 2*DW + $clog2(N);
   localparam int OB = (AW + 7) / 8;
   localparam int IW = $clog2(N*N);
   localparam int CW = $clog2(N);
   localparam int BW = (OB > 1) ? $clog2(OB) : 1;
   localparam logic [CW-1:0] LAST_K = CW'(N-1);
   localparam logic [BW-1:0] LAST_B = BW'(OB-1);
   localparam logic [IW-1:0] LAST_R = IW'(N*N-1);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;
   state_t state, state_nxt;

   logic signed [DW-1:0] a_mem [N*N];
   logic signed [DW-1:0] b_mem [N*N];
   logic signed [AW-1:0] c_mem [N*N];
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] mac_sum;
   logic signed [2*DW-1:0] prod;
   logic [CW-1:0] i_cnt, j_cnt, k_cnt;
   logic [IW-1:0] a_idx, b_idx, c_idx;
   logic [IW-1:0] rd_elem;
   logic [BW-1:0] rd_byte;
   logic          idx_ok, load_wr, last_mac;
   logic [OB*8-1:0] rd_ext, rd_shift;

   assign idx_ok   = int'(load_index) < N*N;
   assign load_wr  = load_en && idx_ok && (state != S_COMPUTE);
   assign a_idx    = IW'(i_cnt) * IW'(N) + IW'(k_cnt);
   assign b_idx    = IW'(k_cnt) * IW'(N) + IW'(j_cnt);
   assign c_idx    = IW'(i_cnt) * IW'(N) + IW'(j_cnt);
   assign prod     = a_mem[a_idx] * b_mem[b_idx];
   assign mac_sum  = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
   assign last_mac = (i_cnt == LAST_K) && (j_cnt == LAST_K) && (k_cnt == LAST_K);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE:    if (start && !load_en) state_nxt = S_COMPUTE;
         S_COMPUTE: begin
            busy = 1'b1;
            if (last_mac) state_nxt = S_DONE;
         end
         S_DONE: begin
            done = 1'b1;
            if (load_en)    state_nxt = S_IDLE;
            else if (start) state_nxt = S_COMPUTE;
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Counters wrap back to zero on the final MAC, so every pass starts from (0,0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int x = 0; x < N*N; x++) begin
            a_mem[x] <= '0;
            b_mem[x] <= '0;
            c_mem[x] <= '0;
         end
         acc     <= '0;
         i_cnt   <= '0;
         j_cnt   <= '0;
         k_cnt   <= '0;
         rd_elem <= '0;
         rd_byte <= '0;
      end else begin
         if (load_wr) begin
            if (load_sel_ab) b_mem[load_index] <= in_data;
            else             a_mem[load_index] <= in_data;
         end
         case (state)
            S_COMPUTE: begin
               rd_elem <= '0;
               rd_byte <= '0;
               if (k_cnt == LAST_K) begin
                  c_mem[c_idx] <= mac_sum;
                  acc          <= '0;
                  k_cnt        <= '0;
                  if (j_cnt == LAST_K) begin
                     j_cnt <= '0;
                     i_cnt <= (i_cnt == LAST_K) ? '0 : i_cnt + CW'(1);
                  end else begin
                     j_cnt <= j_cnt + CW'(1);
                  end
               end else begin
                  acc   <= mac_sum;
                  k_cnt <= k_cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (output_en) begin
                  if (rd_byte == LAST_B) begin
                     rd_byte <= '0;
                     rd_elem <= (rd_elem == LAST_R) ? '0 : rd_elem + IW'(1);
                  end else begin
                     rd_byte <= rd_byte + BW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_ext          = {(OB*8){c_mem[rd_elem][AW-1]}};
      rd_ext[AW-1:0]  = c_mem[rd_elem];
`ifdef TPU_RELU_EN
      if (c_mem[rd_elem][AW-1]) rd_ext = '0;
`endif
      rd_shift = rd_ext >> {rd_byte, 3'b000};
      out_data = (state == S_DONE) ? rd_shift[7:0] : 8'h00;
   end
endmodule

// File: tb/tb_matmul_ctrl.sv
// tb/tb_matmul_ctrl.sv - table-driven self-checking bench for matmul_ctrl (N=2, DW=8)
module tb_matmul_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       load_en;
   logic       load_sel_ab;
   logic [1:0] load_index;
   logic [7:0] in_data;
   logic       start;
   logic       output_en;
   logic [7:0] out_data;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   matmul_ctrl #(.N(2), .DW(8)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_sel_ab(load_sel_ab),
      .load_index(load_index), .in_data(in_data), .start(start),
      .output_en(output_en), .out_data(out_data), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [0:3][7:0]  a;
      logic [0:3][7:0]  b;
      logic [0:3][16:0] c;
   } vec_t;

   vec_t vecs [5];
   logic [0:3][16:0] c_prio;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_byte(input logic [16:0] c, input int b);
      logic [23:0] e;
      e = {{7{c[16]}}, c};
`ifdef TPU_RELU_EN
      if (c[16]) e = '0;
`endif
      return 8'(e >> (8*b));
   endfunction

   task automatic load(input logic sel, input int idx, input logic [7:0] d);
      load_en     = 1'b1;
      load_sel_ab = sel;
      load_index  = 2'(idx);
      in_data     = d;
      tick();
      load_en     = 1'b0;
   endtask

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         load(1'b0, i, v.a[i]);
         load(1'b1, i, v.b[i]);
      end
   endtask

   task automatic wait_done(input string name, input int already);
      int cnt;
      cnt = already;
      while (!done && cnt < 50) begin
         tick();
         cnt++;
      end
      check({name, "_latency"}, cnt, 8);
   endtask

   task automatic read_check(input string name, input logic [0:3][16:0] c);
      for (int e = 0; e < 4; e++) begin
         for (int by = 0; by < 3; by++) begin
            check($sformatf("%s_c%0d_b%0d", name, e, by), int'(out_data), int'(exp_byte(c[e], by)));
            output_en = 1'b1;
            tick();
            output_en = 1'b0;
         end
      end
      check({name, "_wrap"}, int'(out_data), int'(exp_byte(c[0], 0)));
   endtask

   task automatic run_compute(input string name, input logic [0:3][16:0] c);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({name, "_busy"}, int'({busy, done}), 2);
      wait_done(name, 0);
      read_check(name, c);
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_sel_ab = 1'b0; load_index = '0;
      in_data = '0; start = 1'b0; output_en = 1'b0;
      tick();
      tick();
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_out", int'(out_data), 0);
      rst = 1'b0;
      tick();

      // identity, extreme negative, negated identity, general, mixed extremes
      vecs[0].a = {8'h01, 8'h00, 8'h00, 8'h01};
      vecs[0].b = {8'h01, 8'h02, 8'h03, 8'h04};
      vecs[0].c = {17'h00001, 17'h00002, 17'h00003, 17'h00004};
      vecs[1].a = {8'h80, 8'h80, 8'h80, 8'h80};
      vecs[1].b = {8'h80, 8'h80, 8'h80, 8'h80};
      vecs[1].c = {17'h08000, 17'h08000, 17'h08000, 17'h08000};
      vecs[2].a = {8'hFF, 8'h00, 8'h00, 8'hFF};
      vecs[2].b = {8'h05, 8'h00, 8'h00, 8'h05};
      vecs[2].c = {17'h1FFFB, 17'h00000, 17'h00000, 17'h1FFFB};
      vecs[3].a = {8'd1, 8'd2, 8'd3, 8'd4};
      vecs[3].b = {8'd5, 8'd6, 8'd7, 8'd8};
      vecs[3].c = {17'd19, 17'd22, 17'd43, 17'd50};
      vecs[4].a = {8'h7F, 8'h80, 8'hFF, 8'h02};
      vecs[4].b = {8'h7F, 8'h01, 8'h80, 8'hFF};
      vecs[4].c = {17'h07F01, 17'h000FF, 17'h1FE81, 17'h1FFFD};
      c_prio    = {17'd3, 17'd6, 17'd3, 17'd4};

      for (int v = 0; v < 5; v++) begin
         load_vec(vecs[v]);
         run_compute($sformatf("vec%0d", v), vecs[v].c);
      end

      // load/output/start pulses during compute must be ignored
      load_vec(vecs[0]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      load_en = 1'b1; load_sel_ab = 1'b0; load_index = 2'd0; in_data = 8'd9;
      output_en = 1'b1; start = 1'b1;
      tick();
      load_en = 1'b0; output_en = 1'b0; start = 1'b0;
      wait_done("ignore", 3);
      read_check("ignore", vecs[0].c);

      // load_en beats start, both in DONE and in IDLE
      load_en = 1'b1; start = 1'b1; load_sel_ab = 1'b0; load_index = 2'd0; in_data = 8'd3;
      tick();
      load_en = 1'b0; start = 1'b0;
      check("prio_done_clr", int'(done), 0);
      check("prio_done_busy", int'(busy), 0);
      load_en = 1'b1; start = 1'b1; load_sel_ab = 1'b0; load_index = 2'd3; in_data = 8'd1;
      tick();
      load_en = 1'b0; start = 1'b0;
      check("prio_idle_busy", int'(busy), 0);
      run_compute("prio", c_prio);
      output_en = 1'b1;
      tick();
      tick();
      output_en = 1'b0;
      run_compute("restart", c_prio);

      // asynchronous reset in the middle of a pass
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_out", int'(out_data), 0);
      tick();
      rst = 1'b0;
      tick();
      load_vec(vecs[3]);
      run_compute("post_rst", vecs[3].c);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
